// File: rtl/adder_8bit_lf.sv
// 8-bit Ladner-Fischer prefix adder with carry-in/out, plus a registered copy of the result.
// Combinational S/Cout settle with no clock; SUM_R/COUT_R follow one clk later.
// No handshake: registers load every cycle, rst clears them synchronously.
module adder_8bit_lf (
    input  logic       clk,
    input  logic       rst,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    input  logic       A5,
    input  logic       A6,
    input  logic       A7,
    input  logic       A8,
    input  logic       B1,
    input  logic       B2,
    input  logic       B3,
    input  logic       B4,
    input  logic       B5,
    input  logic       B6,
    input  logic       B7,
    input  logic       B8,
    input  logic       Cin,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       S4,
    output logic       S5,
    output logic       S6,
    output logic       S7,
    output logic       S8,
    output logic       Cout,
    output logic [7:0] SUM_R,
    output logic       COUT_R
);

    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic [7:0] s;

    assign a = {A8, A7, A6, A5, A4, A3, A2, A1};
    assign b = {B8, B7, B6, B5, B4, B3, B2, B1};

    // Bit-level generate/propagate.
    assign g = a & b;
    assign p = a ^ b;

    // Cin is folded into bit 0, so every span that reaches bit 0 only needs its G term.
    logic g0;
    assign g0 = g[0] | (p[0] & Cin);

    // Level 1: pairwise spans [1:0], [3:2], [5:4], [7:6].
    logic g1_0;
    logic g3_2, p3_2;
    logic g5_4, p5_4;
    logic g7_6, p7_6;
    assign g1_0 = g[1] | (p[1] & g0);
    assign g3_2 = g[3] | (p[3] & g[2]);
    assign p3_2 = p[3] & p[2];
    assign g5_4 = g[5] | (p[5] & g[4]);
    assign p5_4 = p[5] & p[4];
    assign g7_6 = g[7] | (p[7] & g[6]);
    assign p7_6 = p[7] & p[6];

    // Level 2: spans [2:0], [3:0], [6:4], [7:4]; [1:0] and [5:4] fan out.
    logic g2_0;
    logic g3_0;
    logic g6_4, p6_4;
    logic g7_4, p7_4;
    assign g2_0 = g[2] | (p[2] & g1_0);
    assign g3_0 = g3_2 | (p3_2 & g1_0);
    assign g6_4 = g[6] | (p[6] & g5_4);
    assign p6_4 = p[6] & p5_4;
    assign g7_4 = g7_6 | (p7_6 & g5_4);
    assign p7_4 = p7_6 & p5_4;

    // Level 3: spans [4:0], [5:0], [6:0], [7:0]; [3:0] fans out to all four.
    logic g4_0;
    logic g5_0;
    logic g6_0;
    logic g7_0;
    assign g4_0 = g[4] | (p[4] & g3_0);
    assign g5_0 = g5_4 | (p5_4 & g3_0);
    assign g6_0 = g6_4 | (p6_4 & g3_0);
    assign g7_0 = g7_4 | (p7_4 & g3_0);

    // Carry into each bit is the prefix generate of everything below it.
    assign c = {g7_0, g6_0, g5_0, g4_0, g3_0, g2_0, g1_0, g0, Cin};
    assign s = p ^ c[7:0];

    assign S1   = s[0];
    assign S2   = s[1];
    assign S3   = s[2];
    assign S4   = s[3];
    assign S5   = s[4];
    assign S6   = s[5];
    assign S7   = s[6];
    assign S8   = s[7];
    assign Cout = c[8];

    // Registered copy of the live result for clocked consumers; rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            SUM_R  <= 8'h00;
            COUT_R <= 1'b0;
        end else begin
            SUM_R  <= s;
            COUT_R <= c[8];
        end
    end

endmodule

// File: tb/tb_adder_8bit_lf.sv
// Bench for adder_8bit_lf: expected results queued at drive time, popped when output is sampled.
// Combinational vectors sampled 1 time unit after drive; registered results at the following negedge.
// Covers reset, directed corners, the full exhaustive space and a mid-run reset.
`timescale 1ns/1ps
module tb_adder_8bit_lf;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    wire  [7:0] s;
    wire        cout;
    wire  [7:0] sum_r;
    wire        cout_r;

    int n_vec;
    int n_miss;
    logic [8:0] expq[$];

    adder_8bit_lf dut (
        .clk    (clk),
        .rst    (rst),
        .A1     (a[0]), .A2 (a[1]), .A3 (a[2]), .A4 (a[3]),
        .A5     (a[4]), .A6 (a[5]), .A7 (a[6]), .A8 (a[7]),
        .B1     (b[0]), .B2 (b[1]), .B3 (b[2]), .B4 (b[3]),
        .B5     (b[4]), .B6 (b[5]), .B7 (b[6]), .B8 (b[7]),
        .Cin    (cin),
        .S1     (s[0]), .S2 (s[1]), .S3 (s[2]), .S4 (s[3]),
        .S5     (s[4]), .S6 (s[5]), .S7 (s[6]), .S8 (s[7]),
        .Cout   (cout),
        .SUM_R  (sum_r),
        .COUT_R (cout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected value; an empty queue is itself a miscompare.
    task automatic pop_check(input string tag, input logic [8:0] obs);
        logic [8:0] e;
        if (expq.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            e = expq.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Drive one combinational vector, queue its reference, compare 1 unit later.
    task automatic comb_vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                            input logic vc, input logic [8:0] exp);
        a   = va;
        b   = vb;
        cin = vc;
        expq.push_back(exp);
        #1;
        pop_check(tag, {cout, s});
    endtask

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [8:0] exp;
    } dvec_t;

    dvec_t dir[6];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b1;
        a   = 8'h00;
        b   = 8'h00;
        cin = 1'b0;

        // Reset: two clocks with rst high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_sum_r",  {1'b0, sum_r}, 9'h000);
        check("reset_cout_r", {8'h00, cout_r}, 9'h000);

        // Directed corners, independent of rst.
        dir[0] = '{8'hFF, 8'h00, 1'b1, 9'h100};
        dir[1] = '{8'h00, 8'h00, 1'b1, 9'h001};
        dir[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        dir[3] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
        dir[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
        dir[5] = '{8'h7F, 8'h01, 1'b0, 9'h080};
        for (int i = 0; i < 6; i++) begin
            comb_vec($sformatf("directed%0d", i), dir[i].va, dir[i].vb, dir[i].vc, dir[i].exp);
        end

        // Exhaustive sweep of the combinational path.
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 256; ia++) begin
                for (int ib = 0; ib < 256; ib++) begin
                    comb_vec("exhaustive", 8'(ia), 8'(ib), 1'(ci), 9'(ia + ib + ci));
                end
            end
        end

        // Registered path: release rst and load 0x12 + 0x34 + 1.
        @(negedge clk);
        rst = 1'b0;
        a   = 8'h12;
        b   = 8'h34;
        cin = 1'b1;
        expq.push_back(9'h047);
        @(posedge clk);
        @(negedge clk);
        pop_check("reg_load", {cout_r, sum_r});

        // Registered carry-out: 0xF0 + 0x20 = 0x110.
        a   = 8'hF0;
        b   = 8'h20;
        cin = 1'b0;
        expq.push_back(9'h110);
        @(posedge clk);
        @(negedge clk);
        pop_check("reg_cout", {cout_r, sum_r});

        // Mid-run reset: registers clear, live sum is unaffected.
        a   = 8'h12;
        b   = 8'h34;
        cin = 1'b1;
        rst = 1'b1;
        expq.push_back(9'h000);
        @(posedge clk);
        @(negedge clk);
        pop_check("midrun_rst_reg", {cout_r, sum_r});
        check("midrun_rst_live", {cout, s}, 9'h047);

        // Release again: registers resume tracking the live sum.
        rst = 1'b0;
        expq.push_back(9'h047);
        @(posedge clk);
        @(negedge clk);
        pop_check("reg_resume", {cout_r, sum_r});

        if (expq.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
